// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Bus width, the NOP encoding and the fetch FSM states live here.
package ifu_pkg;

  localparam int unsigned REG_BUS_WIDTH = 32;
  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam int unsigned STALL_IF      = 1;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/dff_lrc.sv
// Register with synchronous active-low reset, synchronous clear and load enable.
// Clear has priority over load; both restore the reset value.
module dff_lrc #(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_o <= RST_VAL;
    end else if (clr_i) begin
      q_o <= RST_VAL;
    end else if (load_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, runs a single-outstanding fetch on the
// instruction bus and presents the pc/inst pair to the IF/ID register.
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned      XLEN     = REG_BUS_WIDTH,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      stall_i,
  output logic            stallreq_o,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            ibus_req_o,
  output logic [XLEN-1:0] ibus_addr_o,
  input  logic            ibus_gnt_i,
  input  logic            ibus_rvalid_i,
  input  logic [31:0]     ibus_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o
);

  ifu_state_e      state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     buf_q;

  logic            stall_if;
  logic            in_req, in_wait, in_hold;
  logic            hit;
  logic            valid_inst;
  logic            consume;
  logic [XLEN-1:0] jump_tgt;
  logic            unused_inputs;

  assign stall_if      = stall_i[STALL_IF];
  assign unused_inputs = ^{stall_i[5:2], stall_i[0], jump_addr_i[1:0]};
  assign jump_tgt      = {jump_addr_i[XLEN-1:2], 2'b00};

  assign in_req  = (state_q == IFU_REQ);
  assign in_wait = (state_q == IFU_WAIT);
  assign in_hold = (state_q == IFU_HOLD);

  assign hit        = in_wait && ibus_rvalid_i && !kill_q;
  assign valid_inst = rst_n && (hit || in_hold);
  assign consume    = valid_inst && !stall_if && !jump_i;

  // stallreq_o depends only on state and bus inputs, never on stall_i.
  assign stallreq_o  = !valid_inst;
  assign ibus_req_o  = rst_n && in_req;
  assign ibus_addr_o = addr_q;
  assign pc_o        = pc_q;

  always_comb begin
    inst_o = INST_NOP;
    if (rst_n) begin
      if (hit) begin
        inst_o = ibus_rdata_i;
      end else if (in_hold) begin
        inst_o = buf_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;

    if (jump_i) begin
      pc_d = jump_tgt;
    end else if (consume) begin
      pc_d = pc_q + XLEN'(4);
    end else begin
      pc_d = pc_q;
    end

    unique case (state_q)
      IFU_REQ: begin
        if (jump_i) begin
          kill_d = 1'b1;
        end
        if (ibus_gnt_i) begin
          state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (ibus_rvalid_i) begin
          kill_d = 1'b0;
          if (kill_q || jump_i || !stall_if) begin
            state_d = IFU_REQ;
          end else begin
            state_d = IFU_HOLD;
          end
        end else if (jump_i) begin
          kill_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (jump_i || !stall_if) begin
          state_d = IFU_REQ;
        end
      end
      default: begin
        state_d = IFU_REQ;
      end
    endcase

    // An ungranted request keeps its address even if a redirect moved pc_q;
    // the stale response is then dropped through kill_q.
    if (in_req && !ibus_gnt_i) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IFU_REQ;
      kill_q  <= 1'b0;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  dff_lrc #(
    .WIDTH   (32),
    .RST_VAL (INST_NOP)
  ) u_inst_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (hit && stall_if),
    .clr_i  (in_hold && jump_i),
    .d_i    (ibus_rdata_i),
    .q_o    (buf_q)
  );

  a_addr_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
      (ibus_req_o && !ibus_gnt_i) |=> (ibus_addr_o == $past(ibus_addr_o))
  );

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a bus model with programmable grant delay and read
// latency, a scoreboard of expected (pc, inst) pairs and a consume monitor.
module tb_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [5:0]  stall_i;
  logic        stallreq_o;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  logic        stallreq2, req2, gnt2, rv2;
  logic [31:0] addr2, rdata2, pc2, inst2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb_q[$];

  int gnt_delay = 0;
  int rv_lat    = 1;

  ifu #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .stallreq_o    (stallreq_o),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o)
  );

  ifu #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (6'b000000),
    .stallreq_o    (stallreq2),
    .jump_i        (1'b0),
    .jump_addr_i   (32'h0000_0000),
    .ibus_req_o    (req2),
    .ibus_addr_o   (addr2),
    .ibus_gnt_i    (gnt2),
    .ibus_rvalid_i (rv2),
    .ibus_rdata_i  (rdata2),
    .pc_o          (pc2),
    .inst_o        (inst2)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Main bus model: grant after gnt_delay waiting cycles, data rv_lat cycles after grant.
  initial begin
    logic        pending, hs_last, prev_wait;
    logic [31:0] hs_addr, pend_addr, prev_addr;
    int          lat, wait_cnt;
    pending = 0; hs_last = 0; prev_wait = 0;
    hs_addr = '0; pend_addr = '0; prev_addr = '0;
    lat = 0; wait_cnt = 0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pending = 0; hs_last = 0; prev_wait = 0; wait_cnt = 0;
        ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 32'hDEAD_BEEF;
      end else begin
        if (ibus_rvalid_i) begin
          ibus_rvalid_i = 0;
          ibus_rdata_i  = 32'hDEAD_BEEF;
          pending       = 0;
        end
        if (hs_last) begin
          pending   = 1;
          pend_addr = hs_addr;
          lat       = rv_lat;
          hs_last   = 0;
        end
        if (pending && !ibus_rvalid_i) begin
          lat--;
          if (lat <= 0) begin
            ibus_rvalid_i = 1;
            ibus_rdata_i  = mem(pend_addr);
          end
        end
        if (prev_wait && ibus_req_o) check("addr_stable", ibus_addr_o, prev_addr);
        ibus_gnt_i = 0;
        if (ibus_req_o) begin
          if (pending) begin
            n_vec++; n_err++;
            $display("FAIL outstanding: got req while busy expected no req (t=%0t)", $time);
          end
          if (wait_cnt >= gnt_delay) begin
            ibus_gnt_i = 1;
            hs_last    = 1;
            hs_addr    = ibus_addr_o;
            wait_cnt   = 0;
          end else begin
            wait_cnt++;
          end
        end
        prev_wait = ibus_req_o && !ibus_gnt_i;
        prev_addr = ibus_addr_o;
      end
    end
  end

  // Zero-wait bus for the second instance.
  initial begin
    logic        hs2;
    logic [31:0] hs2_addr;
    hs2 = 0; hs2_addr = '0;
    gnt2 = 0; rv2 = 0; rdata2 = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        hs2 = 0; gnt2 = 0; rv2 = 0;
      end else begin
        rv2    = hs2;
        rdata2 = hs2 ? mem(hs2_addr) : 32'hDEAD_BEEF;
        hs2    = 0;
        gnt2   = req2;
        if (gnt2) begin
          hs2      = 1;
          hs2_addr = addr2;
        end
      end
    end
  end

  // Monitor: every presented instruction must match the scoreboard head;
  // the head is retired only when the instruction is consumed.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && !stallreq_o && !jump_i) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_unexpected: got pc %h inst %h expected nothing", pc_o, inst_o);
        end else begin
          check("sb_pc", pc_o, sb_q[0].pc);
          check("sb_inst", inst_o, sb_q[0].inst);
          if (!stall_i[1]) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 0; stall_i = '0; jump_i = 0; jump_addr_i = '0;
    repeat (3) cyc();
    check("rst_req", 32'(ibus_req_o), 32'd0);
    check("rst_stallreq", 32'(stallreq_o), 32'd1);
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    check("rst_pc2", pc2, 32'hFFFF_FFFC);
    check("rst_req2", 32'(req2), 32'd0);
    push(32'h0, 32'h0050_0093);
    rst_n = 1;

    cyc(); // c1
    check("c1_req", 32'(ibus_req_o), 32'd1);
    check("c1_addr", ibus_addr_o, 32'h0);
    check("c1_addr2", addr2, 32'hFFFF_FFFC);
    cyc(); // c2
    check("c2_stallreq", 32'(stallreq_o), 32'd0);
    check("c2_inst", inst_o, 32'h0050_0093);
    check("c2_pc", pc_o, 32'h0);
    check("c2_inst2", inst2, 32'h5A5A_FFFC);
    check("c2_pc2", pc2, 32'hFFFF_FFFC);
    rv_lat = 3;
    push(32'h4, 32'hA5A5_0004);
    cyc(); // c3
    check("c3_addr", ibus_addr_o, 32'h4);
    check("c3_addr2_wrap", addr2, 32'h0);
    cyc(); // c4
    check("c4_stallreq", 32'(stallreq_o), 32'd1);
    check("c4_inst", inst_o, NOP);
    cyc(); // c5
    check("c5_stallreq", 32'(stallreq_o), 32'd1);
    check("c5_req", 32'(ibus_req_o), 32'd0);
    cyc(); // c6
    check("c6_inst", inst_o, 32'hA5A5_0004);
    rv_lat = 1;
    push(32'h8, 32'hA5A5_0008);
    cyc(); // c7
    check("c7_single_valid", 32'(stallreq_o), 32'd1);
    check("c7_addr", ibus_addr_o, 32'h8);
    cyc(); // c8
    check("c8_inst", inst_o, 32'hA5A5_0008);
    stall_i = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      cyc(); // c9..c11
      check("hold_req", 32'(ibus_req_o), 32'd0);
      check("hold_inst", inst_o, 32'hA5A5_0008);
      check("hold_pc", pc_o, 32'h8);
    end
    cyc(); // c12
    check("c12_inst", inst_o, 32'hA5A5_0008);
    stall_i = '0;
    rv_lat = 2;
    push(32'h100, 32'hA5A5_0100);
    cyc(); // c13
    check("c13_addr", ibus_addr_o, 32'hC);
    cyc(); // c14
    check("c14_stallreq", 32'(stallreq_o), 32'd1);
    jump_i = 1; jump_addr_i = 32'h0000_0103;
    cyc(); // c15
    jump_i = 0;
    check("c15_killed", 32'(stallreq_o), 32'd1);
    check("c15_inst", inst_o, NOP);
    check("c15_pc", pc_o, 32'h100);
    rv_lat = 1;
    cyc(); // c16
    check("c16_addr", ibus_addr_o, 32'h100);
    cyc(); // c17
    check("c17_inst", inst_o, 32'hA5A5_0100);
    gnt_delay = 2;
    push(32'h200, 32'hA5A5_0200);
    cyc(); // c18
    check("c18_addr", ibus_addr_o, 32'h104);
    jump_i = 1; jump_addr_i = 32'h0000_0200;
    cyc(); // c19
    jump_i = 0;
    check("c19_addr_held", ibus_addr_o, 32'h104);
    check("c19_pc", pc_o, 32'h200);
    cyc(); // c20
    check("c20_addr_held", ibus_addr_o, 32'h104);
    gnt_delay = 0;
    cyc(); // c21
    check("c21_killed", 32'(stallreq_o), 32'd1);
    cyc(); // c22
    check("c22_addr", ibus_addr_o, 32'h200);
    cyc(); // c23
    check("c23_inst", inst_o, 32'hA5A5_0200);
    rv_lat = 3;
    cyc(); // c24
    check("c24_addr", ibus_addr_o, 32'h204);
    cyc(); // c25
    check("c25_wait_req", 32'(ibus_req_o), 32'd0);
    rst_n = 0;
    cyc(); // c26
    check("c26_rst_req", 32'(ibus_req_o), 32'd0);
    check("c26_rst_stallreq", 32'(stallreq_o), 32'd1);
    check("c26_rst_pc", pc_o, 32'h0);
    check("c26_rst_pc2", pc2, 32'hFFFF_FFFC);
    push(32'h0, 32'h0050_0093);
    rv_lat = 1;
    rst_n = 1;
    cyc(); // c27
    check("c27_req", 32'(ibus_req_o), 32'd1);
    check("c27_addr", ibus_addr_o, 32'h0);
    cyc(); // c28
    check("c28_inst", inst_o, 32'h0050_0093);
    push(32'hFFFF_FFFC, 32'h5A5A_FFFC);
    cyc(); // c29
    check("c29_addr", ibus_addr_o, 32'h4);
    jump_i = 1; jump_addr_i = 32'hFFFF_FFFE;
    cyc(); // c30
    jump_i = 0;
    check("c30_killed", 32'(stallreq_o), 32'd1);
    check("c30_pc", pc_o, 32'hFFFF_FFFC);
    cyc(); // c31
    check("c31_addr", ibus_addr_o, 32'hFFFF_FFFC);
    cyc(); // c32
    check("c32_inst", inst_o, 32'h5A5A_FFFC);
    push(32'h0, 32'h0050_0093);
    cyc(); // c33
    check("c33_addr_wrap", ibus_addr_o, 32'h0);
    cyc(); // c34
    check("c34_inst", inst_o, 32'h0050_0093);
    repeat (2) cyc();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
